// File: rtl/lut_loader.sv
// lut_loader: loads SIZE complex coefficients, then streams out every +/- coefficient-sum LUT entry.
//
// Parameters:
//   SIZE    - control bits per LUT entry (1..8); the table has 2**SIZE entries.
//   COEFF_W - signed coefficient width; entries are OUT_W = COEFF_W + $clog2(SIZE) + 1 bits.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   start                  - one-cycle request to begin a table build (only honoured when idle)
//   coef_valid/coef_ready  - coefficient handshake; beats arrive in order j = 0..SIZE-1
//   coef_re/coef_im        - signed coefficient beat
//   wr_valid/wr_ready      - LUT entry write handshake
//   wr_addr                - entry index (control-bit selection vector)
//   wr_re/wr_im            - signed entry value
//   busy                   - high whenever a build is in progress
//   done                   - one-cycle pulse after the final entry write
// Build option:
//   LUT_LOADER_HALF_TABLE_EN - write only entries with index MSB = 0; the reader negates for the rest.
module lut_loader #(
    parameter int SIZE = 4,
    parameter int COEFF_W = 24,
    localparam int OUT_W = COEFF_W + $clog2(SIZE) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      coef_valid,
    output logic                      coef_ready,
    input  logic signed [COEFF_W-1:0] coef_re,
    input  logic signed [COEFF_W-1:0] coef_im,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic        [SIZE-1:0]    wr_addr,
    output logic signed [OUT_W-1:0]   wr_re,
    output logic signed [OUT_W-1:0]   wr_im,
    output logic                      busy,
    output logic                      done
);
    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
`ifdef LUT_LOADER_HALF_TABLE_EN
    localparam logic [SIZE-1:0] LAST = SIZE'((2 ** (SIZE - 1)) - 1);
`else
    localparam logic [SIZE-1:0] LAST = '1;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                    state, state_nx;
    logic [CW-1:0]             cnt;
    logic signed [COEFF_W-1:0] c_re [SIZE];
    logic signed [COEFF_W-1:0] c_im [SIZE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        coef_ready = 1'b0;
        wr_valid   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                coef_ready = 1'b1;
                if (coef_valid && cnt == CW'(SIZE - 1)) state_nx = WRITE;
            end
            WRITE: begin
                wr_valid = 1'b1;
                if (wr_ready && wr_addr == LAST) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            wr_addr <= '0;
            for (int j = 0; j < SIZE; j++) begin
                c_re[j] <= '0;
                c_im[j] <= '0;
            end
        end else begin
            if (state == IDLE && start) begin
                cnt     <= '0;
                wr_addr <= '0;
            end
            if (coef_ready && coef_valid) begin
                c_re[cnt] <= coef_re;
                c_im[cnt] <= coef_im;
                cnt       <= cnt + CW'(1);
            end
            if (wr_valid && wr_ready) wr_addr <= wr_addr + SIZE'(1);
        end
    end

    // Entry value depends only on stored coefficients and the registered address,
    // so the write data never has a combinational path from an input.
    always_comb begin
        wr_re = '0;
        wr_im = '0;
        for (int j = 0; j < SIZE; j++) begin
            wr_re = wr_addr[j] ? wr_re + OUT_W'(c_re[j]) : wr_re - OUT_W'(c_re[j]);
            wr_im = wr_addr[j] ? wr_im + OUT_W'(c_im[j]) : wr_im - OUT_W'(c_im[j]);
        end
    end
endmodule

// File: tb/tb_lut_loader.sv
// tb_lut_loader: randomized, model-checked bench for lut_loader (SIZE=4 main instance, SIZE=2 literal instance).
module tb_lut_loader;
    localparam int SA = 4, SB = 2, CWD = 8;
    localparam int OA = CWD + $clog2(SA) + 1, OB = CWD + $clog2(SB) + 1;
`ifdef LUT_LOADER_HALF_TABLE_EN
    localparam int HALF = 1;
`else
    localparam int HALF = 0;
`endif
    localparam int NA = HALF ? 2 ** (SA - 1) : 2 ** SA;
    localparam int NB = HALF ? 2 ** (SB - 1) : 2 ** SB;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic a_start = 0, a_coef_valid = 0, a_coef_ready, a_wr_valid, a_wr_ready = 0, a_busy, a_done;
    logic signed [CWD-1:0] a_coef_re = 0, a_coef_im = 0;
    logic [SA-1:0] a_wr_addr;
    logic signed [OA-1:0] a_wr_re, a_wr_im;

    logic b_start = 0, b_coef_valid = 0, b_coef_ready, b_wr_valid, b_wr_ready = 0, b_busy, b_done;
    logic signed [CWD-1:0] b_coef_re = 0, b_coef_im = 0;
    logic [SB-1:0] b_wr_addr;
    logic signed [OB-1:0] b_wr_re, b_wr_im;

    lut_loader #(.SIZE(SA), .COEFF_W(CWD)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .coef_valid(a_coef_valid), .coef_ready(a_coef_ready),
        .coef_re(a_coef_re), .coef_im(a_coef_im), .wr_valid(a_wr_valid), .wr_ready(a_wr_ready),
        .wr_addr(a_wr_addr), .wr_re(a_wr_re), .wr_im(a_wr_im), .busy(a_busy), .done(a_done));

    lut_loader #(.SIZE(SB), .COEFF_W(CWD)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .coef_valid(b_coef_valid), .coef_ready(b_coef_ready),
        .coef_re(b_coef_re), .coef_im(b_coef_im), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
        .wr_addr(b_wr_addr), .wr_re(b_wr_re), .wr_im(b_wr_im), .busy(b_busy), .done(b_done));

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Entry i: +c[j] where bit j of i is set, -c[j] otherwise.
    function automatic int lut_sum(input int sz, input int c[8], input int i);
        int s = 0;
        for (int j = 0; j < sz; j++) s += ((i >> j) & 1) ? c[j] : -c[j];
        return s;
    endfunction

    // Behavioural model of instance A, checked on every falling edge.
    int m_phase = 0, m_cnt = 0, m_addr = 0;
    int m_re[8], m_im[8];
    int a_wr_cnt = 0, a_done_cnt = 0;
    int a_cap_re[16];

    always @(negedge clk) begin
        if (rst) begin
            check("rst_coef_ready", a_coef_ready, 0);
            check("rst_wr_valid", a_wr_valid, 0);
            check("rst_busy", a_busy, 0);
            check("rst_done", a_done, 0);
            check("rst_wr_addr", a_wr_addr, 0);
            check("rst_wr_re", a_wr_re, 0);
            check("rst_wr_im", a_wr_im, 0);
            m_phase = 0;
            m_cnt = 0;
            for (int j = 0; j < 8; j++) begin
                m_re[j] = 0;
                m_im[j] = 0;
            end
        end else begin
            check("coef_ready", a_coef_ready, m_phase == 1);
            check("wr_valid", a_wr_valid, m_phase == 2);
            check("busy", a_busy, m_phase != 0);
            check("done", a_done, m_phase == 3);
            if (m_phase == 2) begin
                check("wr_addr", a_wr_addr, m_addr);
                check("wr_re", a_wr_re, lut_sum(SA, m_re, m_addr));
                check("wr_im", a_wr_im, lut_sum(SA, m_im, m_addr));
            end
            if (a_wr_valid && a_wr_ready) begin
                a_wr_cnt++;
                a_cap_re[a_wr_addr] = int'(a_wr_re);
            end
            if (a_done) a_done_cnt++;
            case (m_phase)
                0: if (a_start) begin m_phase = 1; m_cnt = 0; end
                1: if (a_coef_valid) begin
                    m_re[m_cnt] = int'(a_coef_re);
                    m_im[m_cnt] = int'(a_coef_im);
                    m_cnt++;
                    if (m_cnt == SA) begin m_phase = 2; m_addr = 0; end
                end
                2: if (a_wr_ready) begin
                    if (m_addr == NA - 1) m_phase = 3;
                    else m_addr++;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Instance B: capture writes and check stall stability.
    logic [SB-1:0] bq_addr[$];
    int bq_re[$], bq_im[$];
    int b_done_cnt = 0, b_h_re = 0, b_h_im = 0;
    bit b_stall = 0;
    logic [SB-1:0] b_h_addr = 0;

    always @(negedge clk) begin
        if (b_wr_valid && b_stall) begin
            check("b_hold_addr", b_wr_addr, b_h_addr);
            check("b_hold_re", b_wr_re, b_h_re);
            check("b_hold_im", b_wr_im, b_h_im);
        end
        b_stall = b_wr_valid && !b_wr_ready;
        b_h_addr = b_wr_addr;
        b_h_re = int'(b_wr_re);
        b_h_im = int'(b_wr_im);
        if (b_wr_valid && b_wr_ready) begin
            bq_addr.push_back(b_wr_addr);
            bq_re.push_back(int'(b_wr_re));
            bq_im.push_back(int'(b_wr_im));
        end
        if (b_done) b_done_cnt++;
    end

    task automatic a_finish(input bit rnd);
        int k;
        for (k = 0; k < 300; k++) begin
            a_wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            a_start = rnd && ($urandom_range(0, 3) == 0);
            @(posedge clk) #1;
            if (a_done) break;
        end
        a_start = 0;
        a_wr_ready = 0;
        check("a_done_timeout", k < 300, 1);
        @(posedge clk) #1;
        check("a_writes", a_wr_cnt, NA);
        check("a_dones", a_done_cnt, 1);
    endtask

    task automatic a_load(input int re[4], input int im[4], input bit rnd);
        a_wr_cnt = 0;
        a_done_cnt = 0;
        @(posedge clk) #1 a_start = 1;
        @(posedge clk) #1 a_start = 0;
        for (int j = 0; j < SA; j++) begin
            while (rnd && $urandom_range(0, 2) == 0) begin
                a_coef_valid = 0;
                a_start = $urandom_range(0, 3) == 0;
                @(posedge clk) #1;
            end
            a_coef_valid = 1;
            a_coef_re = CWD'(re[j]);
            a_coef_im = CWD'(im[j]);
            a_start = rnd && ($urandom_range(0, 3) == 0);
            @(posedge clk) #1;
        end
        a_coef_valid = 0;
        a_start = 0;
    endtask

    task automatic rand_coefs(output int re[4], output int im[4]);
        for (int j = 0; j < 4; j++) begin
            re[j] = int'($urandom_range(0, 255)) - 128;
            im[j] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic b_build(input bit toggle);
        int k;
        int exp_re[4] = '{-8, -2, 2, 8};
        int exp_im[4] = '{-1, -3, 3, 1};
        bq_addr.delete();
        bq_re.delete();
        bq_im.delete();
        b_done_cnt = 0;
        @(posedge clk) #1 b_start = 1;
        @(posedge clk) #1 b_start = 0;
        b_coef_valid = 1; b_coef_re = 3; b_coef_im = -1;
        @(posedge clk) #1 b_coef_re = 5; b_coef_im = 2;
        @(posedge clk) #1 b_coef_valid = 0;
        for (k = 0; k < 60; k++) begin
            b_wr_ready = toggle ? (k % 3 == 0) : 1'b1;
            @(posedge clk) #1;
            if (b_done) break;
        end
        b_wr_ready = 0;
        check("b_done_timeout", k < 60, 1);
        @(posedge clk) #1;
        check("b_nwrites", bq_addr.size(), NB);
        check("b_dones", b_done_cnt, 1);
        for (int i = 0; i < bq_addr.size() && i < 4; i++) begin
            check("b_addr", bq_addr[i], i);
            check("b_re", bq_re[i], exp_re[i]);
            check("b_im", bq_im[i], exp_im[i]);
        end
    endtask

    initial begin
        int re[4], im[4];
        int k;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk) #1;

        b_build(0);
        b_build(1);

        a_load('{-128, -128, -128, -128}, '{-128, -128, -128, -128}, 0);
        a_finish(0);
        check("r036_entry0", a_cap_re[0], 512);
        check("r036_last", a_cap_re[NA - 1], HALF ? -256 : -512);

        repeat (6) begin
            rand_coefs(re, im);
            a_load(re, im, 1);
            a_finish(1);
        end

        rand_coefs(re, im);
        a_load(re, im, 0);
        for (k = 0; k < 50; k++) begin
            a_wr_ready = 1;
            @(posedge clk) #1;
            if (a_wr_addr == 2) break;
        end
        check("abort_reach_addr2", k < 50, 1);
        rst = 1;
        a_wr_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_wr_re", a_wr_re, 0);
        check("abort_busy", a_busy, 0);
        check("abort_no_done", a_done_cnt, 0);
        rst = 0;
        repeat (2) @(posedge clk);
        #1 check("abort_stays_idle", a_busy, 0);

        rand_coefs(re, im);
        a_load(re, im, 0);
        a_finish(0);
        check("after_abort_entry0", a_cap_re[0], lut_sum(SA, '{re[0], re[1], re[2], re[3], 0, 0, 0, 0}, 0));

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
